// File: rtl/fp32_addtree_operand_aligner.sv
// ---------------------------------------------------------------------------
// fp32_addtree_operand_aligner
//
// Front end of the FP32 5-to-1 adder tree. This block takes in a group of
// NUM_INPUTS FP32 operands over a valid/ready stream and finds the maximum
// effective exponent of the group. It then converts each significand, one per
// cycle, into a right-aligned two's-complement fixed-point word that keeps the
// sticky bit. The aligned group is presented as one flattened bus for the
// downstream compressor tree.
//
// Ports
//   clk          : clock, single domain
//   rst_n        : synchronous active-low reset
//   in_valid     : operand valid
//   in_ready     : block can accept an operand (COLLECT only)
//   in_data      : IEEE-754 single-precision operand
//   out_valid    : aligned group available (OUT state)
//   out_ready    : downstream accepts the group
//   out_data     : NUM_INPUTS*WIDTH aligned operands, slot k = arrival order k
//   out_exp_max  : maximum effective exponent of the group
//   out_nan      : group result is NaN
//   out_inf      : group result is infinite (out_nan clear)
//   out_inf_sign : sign of that infinity
// ---------------------------------------------------------------------------
`ifndef FULL_SUM_WIDTH
`define FULL_SUM_WIDTH 32
`endif

module fp32_addtree_operand_aligner #(
    parameter int NUM_INPUTS = 5,
    parameter int WIDTH      = `FULL_SUM_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_INPUTS*WIDTH-1:0] out_data,
    output logic [7:0]                  out_exp_max,
    output logic                        out_nan,
    output logic                        out_inf,
    output logic                        out_inf_sign
);

    localparam int CW = $clog2(NUM_INPUTS + 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_ALIGN   = 2'd1;
    localparam logic [1:0] S_OUT     = 2'd2;

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_INPUTS - 1);

    logic [1:0]                  r_state;
    logic [CW-1:0]               r_cnt;
    logic [31:0]                 r_slot [NUM_INPUTS];
    logic [7:0]                  r_exp_max;
    logic                        r_any_nan;
    logic                        r_pos_inf;
    logic                        r_neg_inf;
    logic [NUM_INPUTS*WIDTH-1:0] r_out_data;

    // Input-side decode
    logic       w_in_fire;
    logic       w_out_fire;
    logic [7:0] w_in_exp;
    logic [7:0] w_in_eff;
    logic       w_in_is_nan;
    logic       w_in_is_inf;

    // Align-side datapath
    logic [31:0]      w_op;
    logic [7:0]       w_op_eff;
    logic [26:0]      w_m;
    logic [7:0]       w_sh;
    logic [26:0]      w_mask;
    logic             w_sticky;
    logic [26:0]      w_m_al;
    logic [WIDTH-1:0] w_mag_ext;
    logic [WIDTH-1:0] w_word;
    logic             w_special;
    logic             w_nan;
    logic             w_inf;

    assign in_ready   = (r_state == S_COLLECT);
    assign out_valid  = (r_state == S_OUT);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    assign w_in_exp    = in_data[30:23];
    assign w_in_eff    = (w_in_exp == 8'd0) ? 8'd1 : w_in_exp;
    assign w_in_is_nan = (w_in_exp == 8'hFF) && (in_data[22:0] != 23'd0);
    assign w_in_is_inf = (w_in_exp == 8'hFF) && (in_data[22:0] == 23'd0);

    // Opposite infinities in one group collapse to NaN.
    assign w_nan     = r_any_nan | (r_pos_inf & r_neg_inf);
    assign w_inf     = ~w_nan & (r_pos_inf | r_neg_inf);
    assign w_special = r_any_nan | r_pos_inf | r_neg_inf;

    assign out_data     = r_out_data;
    assign out_exp_max  = r_exp_max;
    assign out_nan      = w_nan;
    assign out_inf      = w_inf;
    assign out_inf_sign = w_inf & r_neg_inf;

    // Alignment of the slot selected by r_cnt. r_exp_max is final during ALIGN,
    // so it is always >= the operand's effective exponent and w_sh cannot wrap.
    always_comb begin
        w_op      = r_slot[r_cnt];
        w_op_eff  = (w_op[30:23] == 8'd0) ? 8'd1 : w_op[30:23];
        w_m       = {(w_op[30:23] != 8'd0), w_op[22:0], 3'b000};
        w_sh      = r_exp_max - w_op_eff;
        w_mask    = '0;
        w_m_al    = '0;
        w_sticky  = 1'b0;
        if (w_sh >= 8'd27) begin
            w_m_al   = '0;
            w_sticky = |w_m;
        end else begin
            w_m_al   = w_m >> w_sh;
            w_mask   = ~({27{1'b1}} << w_sh);
            w_sticky = |(w_m & w_mask);
        end
        w_m_al[0] = w_m_al[0] | w_sticky;
        w_mag_ext = {{(WIDTH-27){1'b0}}, w_m_al};
        if (w_special) begin
            w_word = '0;
        end else if (w_op[31]) begin
            w_word = -w_mag_ext;
        end else begin
            w_word = w_mag_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_COLLECT;
            r_cnt      <= '0;
            r_exp_max  <= '0;
            r_any_nan  <= 1'b0;
            r_pos_inf  <= 1'b0;
            r_neg_inf  <= 1'b0;
            r_out_data <= '0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_in_fire) begin
                        r_slot[r_cnt] <= in_data;
                        if (w_in_eff > r_exp_max) begin
                            r_exp_max <= w_in_eff;
                        end
                        if (w_in_is_nan) begin
                            r_any_nan <= 1'b1;
                        end
                        if (w_in_is_inf && !in_data[31]) begin
                            r_pos_inf <= 1'b1;
                        end
                        if (w_in_is_inf && in_data[31]) begin
                            r_neg_inf <= 1'b1;
                        end
                        if (r_cnt == LAST_IDX) begin
                            r_cnt   <= '0;
                            r_state <= S_ALIGN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                // r_cnt is reused as the slot index while aligning.
                S_ALIGN: begin
                    r_out_data[r_cnt*WIDTH +: WIDTH] <= w_word;
                    if (r_cnt == LAST_IDX) begin
                        r_cnt   <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_out_fire) begin
                        r_state   <= S_COLLECT;
                        r_cnt     <= '0;
                        r_exp_max <= '0;
                        r_any_nan <= 1'b0;
                        r_pos_inf <= 1'b0;
                        r_neg_inf <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_addtree_operand_aligner.sv
// ---------------------------------------------------------------------------
// tb_fp32_addtree_operand_aligner
//
// Directed testbench for fp32_addtree_operand_aligner with hand-computed
// expected aligned words, exponents and special flags.
// ---------------------------------------------------------------------------
module tb_fp32_addtree_operand_aligner;

    localparam int N = 5;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic [7:0]     out_exp_max;
    logic           out_nan;
    logic           out_inf;
    logic           out_inf_sign;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] g_ops [N];
    logic [31:0] g_exp [N];

    always #5 clk = ~clk;

    fp32_addtree_operand_aligner #(
        .NUM_INPUTS (N),
        .WIDTH      (W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_exp_max  (out_exp_max),
        .out_nan      (out_nan),
        .out_inf      (out_inf),
        .out_inf_sign (out_inf_sign)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operand after 'gap' idle cycles; returns #1 after the accepting edge.
    task automatic push(input logic [31:0] d, input int gap);
        int waited;
        waited = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check("push_timeout", 64'(waited), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [N*W-1:0] exp_bus();
        logic [N*W-1:0] b;
        for (int k = 0; k < N; k++) b[k*W +: W] = g_exp[k];
        return b;
    endfunction

    // Push g_ops, measure latency, check the group against g_exp and the given
    // flags, hold out_ready low for 'hold' cycles (with junk on in_valid), then handshake.
    task automatic run_group(input string name, input int gap_max, input int hold,
                             input logic [7:0] e_exp, input logic e_nan,
                             input logic e_inf, input logic e_sign);
        int lat;
        for (int k = 0; k < N; k++) push(g_ops[k], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(N));
        check({name, "_exp_max"}, 64'(out_exp_max), 64'(e_exp));
        check({name, "_nan"}, 64'(out_nan), 64'(e_nan));
        check({name, "_inf"}, 64'(out_inf), 64'(e_inf));
        if (e_inf) check({name, "_inf_sign"}, 64'(out_inf_sign), 64'(e_sign));
        for (int k = 0; k < N; k++)
            check($sformatf("%s_slot%0d", name, k), 64'(out_data[k*W +: W]), 64'(g_exp[k]));
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data  = 32'h7FC0_0000;
            for (int c = 0; c < hold; c++) begin
                @(posedge clk);
                #1;
                check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
                check({name, "_hold_ready"}, 64'(in_ready), 64'd0);
                check({name, "_hold_data"}, 64'(out_data == exp_bus()), 64'd1);
                check({name, "_hold_exp"}, 64'(out_exp_max), 64'(e_exp));
                check({name, "_hold_nan"}, 64'(out_nan), 64'(e_nan));
            end
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_post_valid"}, 64'(out_valid), 64'd0);
        check({name, "_post_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data == '0), 64'd1);
        check("rst_exp", 64'(out_exp_max), 64'd0);
        check("rst_flags", 64'({out_nan, out_inf, out_inf_sign}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;

        // Five 1.0 operands
        g_ops = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        g_exp = '{32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000};
        run_group("ones", 0, 0, 8'd127, 1'b0, 1'b0, 1'b0);

        // Mixed signs, zeros of both signs
        g_ops = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h0000_0000, 32'h8000_0000};
        g_exp = '{32'h0200_0000, 32'hFE00_0000, 32'h0400_0000, 32'h0000_0000, 32'h0000_0000};
        run_group("mixed", 0, 0, 8'd128, 1'b0, 1'b0, 1'b0);

        // Shift of 27 leaves only the sticky bit
        g_ops = '{32'h4D00_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        g_exp = '{32'h0400_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        run_group("sticky", 0, 0, 8'd154, 1'b0, 1'b0, 1'b0);

        // Denormals only: effective exponent 1, hidden bit 0
        g_ops = '{32'h0000_0001, 32'h8040_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        g_exp = '{32'h0000_0008, 32'hFE00_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        run_group("denorm", 0, 0, 8'd1, 1'b0, 1'b0, 1'b0);

        // Quiet NaN in slot 2
        g_ops = '{32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000};
        g_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_group("nan", 0, 0, 8'd255, 1'b1, 1'b0, 1'b0);

        // +inf and -inf together
        g_ops = '{32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000};
        run_group("infmix", 0, 0, 8'd255, 1'b1, 1'b0, 1'b0);

        // -inf alone
        g_ops = '{32'h3F80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h3F80_0000};
        run_group("neginf", 0, 0, 8'd255, 1'b0, 1'b1, 1'b1);

        // Random input gaps, output held for 10 cycles
        g_ops = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h0000_0000, 32'h8000_0000};
        g_exp = '{32'h0200_0000, 32'hFE00_0000, 32'h0400_0000, 32'h0000_0000, 32'h0000_0000};
        run_group("flow", 3, 10, 8'd128, 1'b0, 1'b0, 1'b0);

        // Reset after three accepts discards the partial group
        push(32'h4D00_0000, 0);
        push(32'h7F80_0000, 1);
        push(32'h4D00_0000, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_exp", 64'(out_exp_max), 64'd0);
        check("midrst_inf", 64'(out_inf), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_out", 64'(seen), 64'd0);
        g_ops = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        g_exp = '{32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000};
        run_group("after_rst", 0, 0, 8'd127, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
